// File: rtl/tpu_pkg.sv
// Shared types and constants for the matrix-multiply job scheduler.
// Frame geometry, requester count and FSM state encoding.
package tpu_pkg;

    localparam int FRAME_BYTES = 8;
    localparam int N_REQ       = 2;
    localparam int BYTE_CNT_W  = $clog2(FRAME_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RETURN  = 3'd4
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grant, last-grant
// pointer advanced by the update strobe when a job retires.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       update_id,
    output logic [1:0] grant,
    output logic       grant_id
);

    logic last_reg;

    // Pointer starts at 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_reg <= 1'b1;
        end else if (update) begin
            last_reg <= update_id;
        end
    end

    always_comb begin
        grant    = 2'b00;
        grant_id = 1'b0;
        case (req)
            2'b01: begin
                grant    = 2'b01;
                grant_id = 1'b0;
            end
            2'b10: begin
                grant    = 2'b10;
                grant_id = 1'b1;
            end
            2'b11: begin
                grant    = last_reg ? 2'b01 : 2'b10;
                grant_id = ~last_reg;
            end
            default: begin
                grant    = 2'b00;
                grant_id = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mmu_job_scheduler.sv
// Time-shares one 2x2 systolic matmul core between two byte-stream hosts:
// load an 8-byte frame, keep the core stepping while it drains, buffer and return 8 result bytes.
module mmu_job_scheduler
    import tpu_pkg::*;
#(
    parameter int DRAIN_LAT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_transpose,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 out_valid,
    output logic [7:0]           out_data,
    output logic                 out_id,
    input  logic                 out_ready,
    output logic                 core_load_en,
    output logic [7:0]           core_data,
    output logic                 core_transpose,
    input  logic [7:0]           core_outdata,
    output logic                 busy
);

    localparam int LAT_W = (DRAIN_LAT > 1) ? $clog2(DRAIN_LAT) : 1;
    localparam logic [LAT_W-1:0]      LAT_LAST  = LAT_W'(DRAIN_LAT - 1);
    localparam logic [BYTE_CNT_W-1:0] BYTE_LAST = BYTE_CNT_W'(FRAME_BYTES - 1);

    state_t                  state_reg, state_next;
    logic                    g_reg;
    logic                    out_id_reg;
    logic                    core_transpose_reg;
    logic [BYTE_CNT_W-1:0]   byte_cnt_reg;
    logic [LAT_W-1:0]        lat_cnt_reg;
    logic [BYTE_CNT_W-1:0]   cap_cnt_reg;
    logic [BYTE_CNT_W-1:0]   idx_reg;
    logic [7:0]              result_buf_reg [FRAME_BYTES];

    logic [1:0]              arb_grant;
    logic                    arb_grant_id;
    logic                    xfer;
    logic                    last_accept;

    assign xfer        = (state_reg == ST_LOAD) && req_valid[g_reg];
    assign last_accept = (state_reg == ST_RETURN) && out_ready && (idx_reg == BYTE_LAST);

    rr_arbiter2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .update    (last_accept),
        .update_id (g_reg),
        .grant     (arb_grant),
        .grant_id  (arb_grant_id)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg          <= ST_IDLE;
            g_reg              <= 1'b0;
            out_id_reg         <= 1'b0;
            core_transpose_reg <= 1'b0;
            byte_cnt_reg       <= '0;
            lat_cnt_reg        <= '0;
            cap_cnt_reg        <= '0;
            idx_reg            <= '0;
            for (int i = 0; i < FRAME_BYTES; i++) begin
                result_buf_reg[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    // Grant, owner id and transpose are all frozen here for the whole job.
                    if (|req_valid) begin
                        g_reg              <= arb_grant_id;
                        out_id_reg         <= arb_grant_id;
                        core_transpose_reg <= |(req_transpose & arb_grant);
                    end
                    byte_cnt_reg <= '0;
                    lat_cnt_reg  <= '0;
                    cap_cnt_reg  <= '0;
                    idx_reg      <= '0;
                end
                ST_LOAD: begin
                    if (xfer) begin
                        byte_cnt_reg <= byte_cnt_reg + 1'b1;
                    end
                end
                ST_WAIT: begin
                    lat_cnt_reg <= lat_cnt_reg + 1'b1;
                end
                ST_CAPTURE: begin
                    result_buf_reg[cap_cnt_reg] <= core_outdata;
                    cap_cnt_reg                 <= cap_cnt_reg + 1'b1;
                end
                ST_RETURN: begin
                    if (out_ready) begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_next   = state_reg;
        req_ready    = '0;
        core_load_en = 1'b0;
        core_data    = 8'h00;
        out_valid    = 1'b0;
        out_data     = 8'h00;
        case (state_reg)
            ST_IDLE: begin
                if (|req_valid) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                req_ready[g_reg] = 1'b1;
                core_load_en     = req_valid[g_reg];
                if (req_valid[g_reg]) begin
                    core_data = req_data[{g_reg, 3'b000} +: 8];
                end
                if (xfer && (byte_cnt_reg == BYTE_LAST)) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Zero bytes keep the array clocking so earlier partial sums drain out.
                core_load_en = 1'b1;
                if (lat_cnt_reg == LAT_LAST) begin
                    state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                core_load_en = 1'b1;
                if (cap_cnt_reg == BYTE_LAST) begin
                    state_next = ST_RETURN;
                end
            end
            ST_RETURN: begin
                out_valid = 1'b1;
                out_data  = result_buf_reg[idx_reg];
                if (out_ready && (idx_reg == BYTE_LAST)) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign out_id         = out_id_reg;
    assign core_transpose = core_transpose_reg;
    assign busy           = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_mmu_job_scheduler.sv
// Directed bench for mmu_job_scheduler with a pulse-counting core model
// whose result bytes are base+k, presented DRAIN_LAT steps after the 8th load.
module tb_mmu_job_scheduler;

    localparam int DRAIN = 3;
    localparam int LO    = 8 + DRAIN;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_transpose;
    logic [1:0]  req_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_id;
    logic        out_ready;
    logic        core_load_en;
    logic [7:0]  core_data;
    logic        core_transpose;
    logic [7:0]  core_outdata;
    logic        busy;

    logic [7:0]  core_base;
    logic [7:0]  mcnt;
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    mmu_job_scheduler #(.DRAIN_LAT(DRAIN)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_transpose  (req_transpose),
        .req_ready      (req_ready),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_id         (out_id),
        .out_ready      (out_ready),
        .core_load_en   (core_load_en),
        .core_data      (core_data),
        .core_transpose (core_transpose),
        .core_outdata   (core_outdata),
        .busy           (busy)
    );

    // Core model: counts load_en pulses within a job; pulses LO..LO+7 carry results.
    always @(posedge clk or posedge rst) begin
        if (rst)               mcnt <= 8'd0;
        else if (!busy)        mcnt <= 8'd0;
        else if (core_load_en) mcnt <= mcnt + 8'd1;
    end
    assign core_outdata = (mcnt >= 8'(LO) && mcnt < 8'(LO + 8)) ? core_base + (mcnt - 8'(LO)) : 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_id"}, out_id, 0);
        chk({tag, "_core_load_en"}, core_load_en, 0);
        chk({tag, "_core_data"}, core_data, 0);
        chk({tag, "_core_transpose"}, core_transpose, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // One full job for requester r, starting in IDLE.
    task automatic do_job(input int r, input logic [7:0] first, input logic tr,
                          input logic [7:0] base, input bit gaps, input bit bp, input bit hold);
        int xf;
        int k;
        int guard;
        logic [1:0] exp_rdy;
        exp_rdy = 2'(1 << r);
        chk("idle_busy", busy, 0);
        core_base              = base;
        req_valid[r]           = 1'b1;
        req_data[8*r +: 8]     = first;
        req_data[8*(1-r) +: 8] = 8'hEE;
        req_transpose[r]       = tr;
        #1;
        chk("idle_req_ready", req_ready, 0);
        tick();
        chk("grant_ready", req_ready, exp_rdy);
        chk("grant_out_id", out_id, r);
        chk("grant_transpose", core_transpose, tr);
        xf = 0;
        guard = 0;
        while (xf < 8 && guard < 40) begin
            req_valid[r]       = !(gaps && guard[0]);
            req_transpose[r]   = gaps ? (tr ^ guard[0]) : tr;
            req_data[8*r +: 8] = first + 8'(xf);
            #1;
            chk("load_en", core_load_en, req_valid[r]);
            chk("load_data", core_data, req_valid[r] ? first + 8'(xf) : 8'h00);
            chk("load_transpose", core_transpose, tr);
            if (req_valid[r]) xf++;
            tick();
            guard++;
        end
        if (xf < 8) chk("load_timeout", xf, 8);
        req_valid[r]     = hold;
        req_transpose[r] = tr;
        out_ready        = 1'b1;
        for (int i = 0; i < DRAIN + 8; i++) begin
            #1;
            chk("drain_load_en", core_load_en, 1);
            chk("drain_data", core_data, 0);
            chk("drain_ready", req_ready, 0);
            chk("drain_out_valid", out_valid, 0);
            tick();
        end
        k = 0;
        guard = 0;
        while (k < 8 && guard < 40) begin
            out_ready = bp ? !guard[0] : 1'b1;
            #1;
            chk("ret_valid", out_valid, 1);
            chk("ret_data", out_data, base + 8'(k));
            chk("ret_id", out_id, r);
            chk("ret_ready", req_ready, 0);
            if (out_ready) k++;
            tick();
            guard++;
        end
        if (k < 8) chk("ret_timeout", k, 8);
        #1;
        chk("end_busy", busy, 0);
        chk("end_out_valid", out_valid, 0);
        $display("job r=%0d first=%0h base=%0h gaps=%0d bp=%0d done checks=%0d failures=%0d",
                 r, first, base, gaps, bp, checks, failures);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        req_valid     = 2'b00;
        req_data      = 16'h0000;
        req_transpose = 2'b00;
        out_ready     = 1'b1;
        core_base     = 8'h00;
        #3;
        chk_zero("reset");
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("post_reset_busy", busy, 0);

        // Single job, requester 0, bytes 1..8, results 0x10..0x17.
        do_job(0, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0);

        // Contention from reset: 0 first, then 1 while 0 re-requests, then 0.
        rst       = 1'b1;
        req_valid = 2'b11;
        req_data  = 16'hEEEE;
        tick();
        tick();
        rst = 1'b0;
        do_job(0, 8'h01, 1'b0, 8'h20, 1'b0, 1'b0, 1'b1);
        do_job(1, 8'h11, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);
        do_job(0, 8'h41, 1'b1, 8'h50, 1'b0, 1'b0, 1'b0);

        // Gapped input with mid-frame transpose wiggle, requester 1.
        do_job(1, 8'h21, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0);

        // Backpressure on requester 0 while requester 1 waits.
        req_valid[1]     = 1'b1;
        req_transpose[1] = 1'b1;
        do_job(0, 8'hA1, 1'b0, 8'h90, 1'b0, 1'b1, 1'b0);

        // Requester 1 is now granted; reset asynchronously after 5 bytes.
        tick();
        chk("r1_grant_ready", req_ready, 2'b10);
        chk("r1_grant_id", out_id, 1);
        chk("r1_grant_transpose", core_transpose, 1);
        for (int i = 0; i < 5; i++) begin
            req_data[15:8] = 8'h30 + 8'(i);
            #1;
            chk("part_load_en", core_load_en, 1);
            chk("part_load_data", core_data, 8'h30 + 8'(i));
            tick();
        end
        #1;
        rst = 1'b1;
        #1;
        chk_zero("midrst");
        req_valid     = 2'b00;
        req_transpose = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rel_busy", busy, 0);
        chk("rel_req_ready", req_ready, 0);
        do_job(1, 8'h51, 1'b0, 8'h60, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
